// File: rtl/occupancy_pkg.sv
// Shared types for the occupancy-grid front-end arbiter.
package occupancy_pkg;

  localparam int GRID_X_W = 8;
  localparam int GRID_Y_W = 7;
  localparam int CELL_W   = 8;

  typedef struct packed {
    logic [GRID_X_W-1:0] x;
    logic [GRID_Y_W-1:0] y;
  } cell_addr_t;

  typedef struct packed {
    cell_addr_t addr;
    logic       free;
  } wr_entry_t;

  // Arbiter states, kept as plain constants for legacy tool flows.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE       = 2'd0;
  localparam arb_state_t WRITE_WAIT = 2'd1;
  localparam arb_state_t READ_WAIT  = 2'd2;
  localparam arb_state_t CLEAR_WAIT = 2'd3;

endpackage

// File: rtl/occupancy_wr_fifo.sv
// Small write-request FIFO between the ray tracer and the arbiter.
// A push while full is dropped even if a pop happens the same cycle.
module occupancy_wr_fifo
  import occupancy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  wr_entry_t din,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wr_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue outright.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/occupancy_arbiter.sv
// Front-end scheduler sharing the occupancy grid between map clear,
// ray-tracer cell updates and scan-matcher reads. Grid strobes and the
// address are driven combinationally in the issue cycle and the address
// then holds until the next operation.
// Optional: define OCC_ARB_STATS_EN for write/read/stall statistics ports.
module occupancy_arbiter
  import occupancy_pkg::*;
#(
  parameter int WR_FIFO_DEPTH  = 4,
  parameter int MAX_READ_BURST = 4,
  parameter int READ_LATENCY   = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear_req,
  output logic                clear_done,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [GRID_X_W-1:0] wr_x,
  input  logic [GRID_Y_W-1:0] wr_y,
  input  logic                wr_free,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [GRID_X_W-1:0] rd_x,
  input  logic [GRID_Y_W-1:0] rd_y,
  output logic                rd_data_valid,
  output logic [CELL_W-1:0]   rd_data,
  output logic                grid_zero_memory,
  output logic                grid_we,
  output logic [GRID_X_W-1:0] grid_x,
  output logic [GRID_Y_W-1:0] grid_y,
  output logic                grid_cell_is_free,
  input  logic [CELL_W-1:0]   grid_data_out,
  input  logic                grid_busy
`ifdef OCC_ARB_STATS_EN
  ,
  output logic [15:0]         stat_writes,
  output logic [15:0]         stat_reads,
  output logic [15:0]         stat_stalls
`endif
);

  localparam int SW = $clog2(MAX_READ_BURST + 1);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_READ_BURST);
  localparam logic [LW-1:0] LAT        = LW'(READ_LATENCY);

  arb_state_t          state;
  logic                clear_pending;
  logic [SW-1:0]       read_streak;
  logic [LW-1:0]       lat_cnt;
  logic [GRID_X_W-1:0] last_x;
  logic [GRID_Y_W-1:0] last_y;
  logic                last_free;

  logic      fifo_full, fifo_empty, fifo_push;
  wr_entry_t fifo_din, fifo_head;
  logic      go, issue_clr, issue_wr, issue_rd;

  // Arbitration: clear first, then a write when reads are idle or have used up their burst.
  assign go        = (state == IDLE) & ~grid_busy & ~reset;
  assign issue_clr = go & clear_pending;
  assign issue_wr  = go & ~clear_pending & ~fifo_empty & (~rd_valid | (read_streak == STREAK_MAX));
  assign issue_rd  = go & ~clear_pending & rd_valid & ~issue_wr;

  assign rd_ready  = issue_rd;
  assign wr_ready  = ~reset & ~fifo_full & ~clear_pending & (state != CLEAR_WAIT);
  assign fifo_push = wr_valid & wr_ready;
  assign fifo_din  = '{addr: '{x: wr_x, y: wr_y}, free: wr_free};

  assign grid_zero_memory  = issue_clr;
  assign grid_we           = issue_wr;
  assign grid_x            = issue_wr ? fifo_head.addr.x : (issue_rd ? rd_x : last_x);
  assign grid_y            = issue_wr ? fifo_head.addr.y : (issue_rd ? rd_y : last_y);
  assign grid_cell_is_free = issue_wr ? fifo_head.free : last_free;
  assign clear_done        = (state == CLEAR_WAIT) & ~grid_busy;

  occupancy_wr_fifo #(.DEPTH(WR_FIFO_DEPTH)) u_wr_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (issue_wr),
    .flush (issue_clr),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Main FSM, pending-clear latch and read return path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
      lat_cnt       <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      if (issue_clr)                             clear_pending <= 1'b0;
      else if (clear_req && state != CLEAR_WAIT) clear_pending <= 1'b1;
      case (state)
        IDLE: begin
          if (issue_clr)     state <= CLEAR_WAIT;
          else if (issue_wr) state <= WRITE_WAIT;
          else if (issue_rd) begin
            state   <= READ_WAIT;
            lat_cnt <= LW'(1);
          end
        end
        WRITE_WAIT, CLEAR_WAIT: if (!grid_busy) state <= IDLE;
        READ_WAIT: begin
          if (lat_cnt == LAT) begin
            rd_data       <= grid_data_out;
            rd_data_valid <= 1'b1;
            state         <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read streak: counts reads granted while writes wait; an empty FIFO or a write restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       read_streak <= '0;
    else if (issue_wr || fifo_empty)                 read_streak <= '0;
    else if (issue_rd && read_streak != STREAK_MAX)  read_streak <= read_streak + 1'b1;
  end

  // Hold the address and polarity of the last issued operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_x    <= '0;
      last_y    <= '0;
      last_free <= 1'b0;
    end else if (issue_wr || issue_rd) begin
      last_x    <= grid_x;
      last_y    <= grid_y;
      last_free <= grid_cell_is_free;
    end
  end

`ifdef OCC_ARB_STATS_EN
  // Saturating statistics, restarted by every clear issue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset || issue_clr) begin
      stat_writes <= '0;
      stat_reads  <= '0;
      stat_stalls <= '0;
    end else begin
      if (issue_wr && stat_writes != 16'hFFFF)              stat_writes <= stat_writes + 1'b1;
      if (issue_rd && stat_reads != 16'hFFFF)               stat_reads  <= stat_reads + 1'b1;
      if (wr_valid && !wr_ready && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_occupancy_arbiter.sv
// Self-checking bench for occupancy_arbiter: directed scenarios followed by
// random traffic, all compared cycle by cycle against a queue-based model.
// Honours OCC_ARB_STATS_EN when defined.
module tb_occupancy_arbiter;

  localparam int DEPTH = 4;
  localparam int BURST = 4;
  localparam int RL    = 2;
  localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_CLR = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 0, wr_valid = 0, wr_free = 0, rd_valid = 0, grid_busy = 0;
  logic [7:0] wr_x = 0, rd_x = 0, grid_data_out = 0;
  logic [6:0] wr_y = 0, rd_y = 0;
  logic       clear_done, wr_ready, rd_ready, rd_data_valid;
  logic       grid_zero_memory, grid_we, grid_cell_is_free;
  logic [7:0] rd_data, grid_x;
  logic [6:0] grid_y;
`ifdef OCC_ARB_STATS_EN
  logic [15:0] stat_writes, stat_reads, stat_stalls;
`endif

  always #5 clock = ~clock;

  occupancy_arbiter #(.WR_FIFO_DEPTH(DEPTH), .MAX_READ_BURST(BURST), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset), .clear_req(clear_req), .clear_done(clear_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_free(wr_free),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .grid_zero_memory(grid_zero_memory), .grid_we(grid_we), .grid_x(grid_x), .grid_y(grid_y),
    .grid_cell_is_free(grid_cell_is_free), .grid_data_out(grid_data_out), .grid_busy(grid_busy)
`ifdef OCC_ARB_STATS_EN
    , .stat_writes(stat_writes), .stat_reads(stat_reads), .stat_stalls(stat_stalls)
`endif
  );

  int n_chk = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Grid contents as seen by the bench; (200,100) holds A5.
  function automatic logic [7:0] cell_val(input int x, input int y);
    if (x == 200 && y == 100) return 8'hA5;
    return 8'((x * 5) ^ (y * 3) ^ 60);
  endfunction

  // Reference model: pending writes in a queue, plus the operation in flight.
  typedef struct { int x; int y; bit f; } ent_t;
  typedef struct { int c; logic [15:0] a; } we_rec_t;
  ent_t    q[$];
  we_rec_t we_log[$];
  bit      cp;
  int      streak, kind, due, rax, ray, lx, ly;
  bit      lf, e_rdv;
  logic [7:0] e_rdata;
  int      sw, sr, ss;

  // Grid model and stimulus knobs.
  int      bcnt = 0, clr_dur = 2;
  bit      busy_force = 0, spur_en = 0, rand_dur = 0, strobe;
  logic [7:0] pipe [RL];
  bit      m_push, m_rd;

  // Observation logs.
  int      zero_cnt, zero_cyc, done_cnt, done_cyc, rdv_cnt = 0;
  logic [7:0] last_rdata;
  bit      log_en = 0;
  int      pat, npat;

  task automatic model_reset();
    q.delete(); cp = 0; streak = 0; kind = K_NONE; due = 0;
    e_rdv = 0; e_rdata = 0; lx = 0; ly = 0; lf = 0; sw = 0; sr = 0; ss = 0;
  endtask

  // One clock: check at the falling edge, advance the model, then drive grid responses.
  task automatic cycle();
    bit go, e_clr, e_wr, e_rd, e_wrr, e_done, push, n_rdv;
    int ex, ey, dur;
    bit ef;
    logic [7:0] n_rdata;
    @(negedge clock);
    cyc++;
    m_push = 0; m_rd = 0; strobe = 0; dur = 0; ex = 0; ey = 0; ef = 0;
    if (reset) begin
      chk("reset_outputs", {2'b0, wr_ready, rd_ready, rd_data_valid, clear_done, grid_zero_memory,
          grid_we, grid_cell_is_free, grid_x, grid_y, rd_data}, 32'h0);
`ifdef OCC_ARB_STATS_EN
      chk("reset_stats", {stat_writes | stat_reads | stat_stalls}, 0);
`endif
      model_reset();
    end else begin
      go     = (kind == K_NONE) && !grid_busy;
      e_clr  = go && cp;
      e_wr   = go && !cp && q.size() > 0 && (!rd_valid || streak == BURST);
      e_rd   = go && !cp && rd_valid && !e_wr;
      e_wrr  = q.size() < DEPTH && !cp && kind != K_CLR;
      e_done = kind == K_CLR && !grid_busy;
      ex = lx; ey = ly; ef = lf;
      if (e_wr) begin ex = q[0].x; ey = q[0].y; ef = q[0].f; end
      else if (e_rd) begin ex = rd_x; ey = rd_y; end
      chk("wr_ready", wr_ready, e_wrr);
      chk("rd_ready", rd_ready, e_rd);
      chk("grid_we", grid_we, e_wr);
      chk("grid_zero_memory", grid_zero_memory, e_clr);
      chk("clear_done", clear_done, e_done);
      chk("rd_data_valid", rd_data_valid, e_rdv);
      chk("rd_data", rd_data, e_rdata);
      chk("grid_addr", {grid_x, grid_y, grid_cell_is_free}, {8'(ex), 7'(ey), ef});
`ifdef OCC_ARB_STATS_EN
      chk("stat_writes", stat_writes, sw);
      chk("stat_reads", stat_reads, sr);
      chk("stat_stalls", stat_stalls, ss);
`endif
      // Observations taken from the DUT for the directed scenarios.
      if (grid_we) we_log.push_back('{cyc, {grid_x, grid_y, grid_cell_is_free}});
      if (grid_zero_memory) begin zero_cnt++; zero_cyc = cyc; end
      if (clear_done) begin done_cnt++; done_cyc = cyc; end
      if (rd_data_valid) begin rdv_cnt++; last_rdata = rd_data; end
      if (log_en && npat < 10 && (grid_we || rd_ready)) begin
        pat = (pat << 1) | int'(grid_we);
        npat++;
      end
      // Advance the model.
      push = wr_valid && e_wrr;
      if (e_clr) begin sw = 0; sr = 0; ss = 0; end
      else begin
        if (e_wr && sw < 65535) sw++;
        if (e_rd && sr < 65535) sr++;
        if (wr_valid && !e_wrr && ss < 65535) ss++;
      end
      if (e_wr || q.size() == 0) streak = 0;
      else if (e_rd && streak < BURST) streak++;
      if (e_clr) q.delete();
      else if (e_wr) void'(q.pop_front());
      if (push) q.push_back('{int'(wr_x), int'(wr_y), wr_free});
      if (e_clr) cp = 0;
      else if (clear_req && kind != K_CLR) cp = 1;
      n_rdv = 0; n_rdata = e_rdata;
      case (kind)
        K_NONE: begin
          if (e_clr) kind = K_CLR;
          else if (e_wr) kind = K_WR;
          else if (e_rd) begin kind = K_RD; due = cyc + RL; rax = ex; ray = ey; end
        end
        K_WR, K_CLR: if (!grid_busy) kind = K_NONE;
        default: if (cyc == due) begin n_rdv = 1; n_rdata = cell_val(rax, ray); kind = K_NONE; end
      endcase
      e_rdv = n_rdv; e_rdata = n_rdata;
      lx = ex; ly = ey; lf = ef;
      m_push = push; m_rd = e_rd;
      strobe = e_wr || e_clr;
      dur = e_clr ? clr_dur : (rand_dur ? int'($urandom_range(0, 3)) : 0);
    end
    if (reset) bcnt = 0;
    else if (strobe) bcnt = dur;
    else if (bcnt > 0) bcnt--;
    else if (spur_en && $urandom_range(0, 15) == 0) bcnt = 1;
    for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = cell_val(ex, ey);
    @(posedge clock);
    #1;
    grid_busy     = busy_force || (bcnt > 0);
    grid_data_out = pipe[RL-1];
  endtask

  task automatic push_wr(input int x, input int y, input bit f);
    bit ok = 0;
    wr_valid = 1; wr_x = 8'(x); wr_y = 7'(y); wr_free = f;
    for (int i = 0; i < 200 && !ok; i++) begin
      cycle();
      ok = m_push;
    end
    wr_valid = 0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic rd_one(input int x, input int y);
    bit ok = 0;
    rd_valid = 1; rd_x = 8'(x); rd_y = 7'(y);
    for (int i = 0; i < 200 && !ok; i++) begin
      cycle();
      ok = m_rd;
    end
    rd_valid = 0;
    if (!ok) chk("read_timeout", 0, 1);
  endtask

  task automatic hold_busy();
    busy_force = 1; grid_busy = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t1x[3] = '{10, 11, 12};
    int t1y[3] = '{5, 5, 6};
    bit t1f[3] = '{1, 1, 0};
    int rdv0, wc;
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    model_reset();
    #1;
    repeat (3) cycle();
    reset = 0;
    cycle();

    // Three updates with an idle grid: ordered grid_we pulses two cycles apart.
    we_log.delete();
    for (int i = 0; i < 3; i++) push_wr(t1x[i], t1y[i], t1f[i]);
    repeat (8) cycle();
    chk("t1_we_count", we_log.size(), 3);
    for (int i = 0; i < 3 && i < we_log.size(); i++) begin
      chk("t1_order", we_log[i].a, {8'(t1x[i]), 7'(t1y[i]), t1f[i]});
      if (i > 0) chk("t1_gap", we_log[i].c - we_log[i-1].c, 2);
    end

    // Fill the FIFO behind a busy grid, then hold wr_valid against a full FIFO.
    hold_busy();
    for (int i = 0; i < DEPTH; i++) push_wr(20 + i, 9, i[0]);
    wr_valid = 1; wr_x = 8'd99; wr_y = 7'd1;
    repeat (3) begin
      cycle();
      chk("t2_full_wr_ready", wr_ready, 0);
    end
    wr_valid = 0;
    busy_force = 0;
    repeat (20) cycle();

    // Continuous reads with two queued writes: RRRRW RRRRW.
    rand_dur = 1;
    hold_busy();
    push_wr(30, 3, 1);
    push_wr(31, 3, 0);
    busy_force = 0;
    pat = 0; npat = 0; log_en = 1;
    rd_valid = 1;
    for (int i = 0; i < 300 && npat < 10; i++) begin
      rd_x = 8'($urandom); rd_y = 7'($urandom);
      cycle();
    end
    rd_valid = 0; log_en = 0;
    chk("t3_burst_pattern", pat, 32'b0000100001);
    repeat (10) cycle();

    // Read of (200,100) returns A5.
    rdv0 = rdv_cnt;
    rd_one(200, 100);
    for (int i = 0; i < 30 && rdv_cnt == rdv0; i++) cycle();
    chk("t4_rd_returned", rdv_cnt - rdv0, 1);
    chk("t4_rd_data", last_rdata, 8'hA5);

    // Clear with two writes queued and a 50-cycle busy grid.
    hold_busy();
    push_wr(40, 2, 1);
    push_wr(41, 2, 1);
    clear_req = 1;
    cycle();
    clear_req = 0;
    clr_dur = 50;
    busy_force = 0;
    zero_cnt = 0; done_cnt = 0; we_log.delete();
    repeat (70) cycle();
    chk("t5_zero_pulses", zero_cnt, 1);
    chk("t5_flushed_no_we", we_log.size(), 0);
    chk("t5_done_pulses", done_cnt, 1);
    chk("t5_done_on_busy_fall", done_cyc - zero_cyc, 51);
    clr_dur = 2;

    // Reset while a read is outstanding: nothing comes back.
    rd_one(3, 4);
    cycle();
    reset = 1;
    cycle();
    chk("t6_rd_ready_in_reset", {rd_ready, grid_we, grid_zero_memory, rd_data_valid}, 0);
    reset = 0;
    rdv0 = rdv_cnt;
    repeat (10) cycle();
    chk("t6_no_rd_after_reset", rdv_cnt - rdv0, 0);

    // Random traffic.
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      wr_valid  = ($urandom_range(0, 2) != 0);
      wr_x      = 8'($urandom); wr_y = 7'($urandom); wr_free = 1'($urandom);
      rd_valid  = ($urandom_range(0, 2) == 0);
      rd_x      = 8'($urandom); rd_y = 7'($urandom);
      clear_req = ($urandom_range(0, 59) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      clr_dur   = $urandom_range(0, 5);
      cycle();
    end
    reset = 0; wr_valid = 0; rd_valid = 0; clear_req = 0;
    wc = n_chk;
    repeat (10) cycle();
    chk("checks_progress", (n_chk > wc), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
